// File: rtl/fifo_rd_arbiter_if.sv
// Read-port bundle shared between the FIFO read side, its consumers and the arbiter.
// master = arbiter view, slave = FIFO/consumer environment view.
interface fifo_rd_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]    rd_req;
    logic                  f_empty;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  r_en;
    logic [NUM_REQ-1:0]    gnt;
    logic [DATA_WIDTH-1:0] data_out;
    logic [NUM_REQ-1:0]    rd_valid;

    modport master (
        input  rd_req, f_empty, mem_data_out,
        output r_en, gnt, data_out, rd_valid
    );

    modport slave (
        output rd_req, f_empty, mem_data_out,
        input  r_en, gnt, data_out, rd_valid
    );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing one async-FIFO read port among NUM_REQ consumers (r_clk domain).
// Optional macro RD_ARB_TIMEOUT_EN releases a grant after TIMEOUT_CYC consecutive empty-stall cycles.
module fifo_rd_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REQ     = 4,
    parameter int BURST_MAX   = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                r_clk,
    input  logic                rrst_n,
    fifo_rd_arbiter_if.master   bus
);
    localparam int OW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [OW-1:0]         owner_q, owner_d;
    logic [OW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [3:0]            beat_q, beat_d;
    logic [OW-1:0]         sel;
    int                    idx;
    logic                  r_en;
    logic                  burst_done;
    logic                  timeout_hit;

    // Owner tag travels with the read so delivery is correct after gnt moves on.
    logic                  pend_q;
    logic [OW-1:0]         pend_owner_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [NUM_REQ-1:0]    valid_q;

    // Lowest offset from rr_ptr+1 wins: iterate downward so the closest requester is assigned last.
    always_comb begin
        sel = rr_ptr_q;
        idx = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (bus.rd_req[idx]) sel = OW'(idx);
        end
    end

    // Output process: read strobe is combinational from registered state and live inputs.
    always_comb begin
        r_en = (state_q == READ) && !bus.f_empty && bus.rd_req[owner_q];
    end

    assign burst_done = r_en && (beat_q == 4'(BURST_MAX - 1));

`ifdef RD_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYC + 1);
    logic [SW-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = '0;
        if (state_q == READ) begin
            if (r_en)             stall_d = '0;
            else if (bus.f_empty) stall_d = stall_q + 1'b1;
            else                  stall_d = stall_q;
        end
    end

    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) stall_q <= '0;
        else         stall_q <= stall_d;
    end

    assign timeout_hit = (state_q == READ) && bus.f_empty && (stall_q == SW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state process.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        beat_d   = beat_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.rd_req) begin
                    state_d      = READ;
                    owner_d      = sel;
                    gnt_d        = '0;
                    gnt_d[sel]   = 1'b1;
                    beat_d       = '0;
                end
            end
            READ: begin
                if (r_en) beat_d = beat_q + 1'b1;
                if (burst_done || !bus.rd_req[owner_q] || timeout_hit) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = owner_q;
                    beat_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register process.
    always_ff @(posedge r_clk or negedge rrst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rrst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= OW'(NUM_REQ - 1);
            gnt_q    <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            beat_q   <= beat_d;
        end
    end

    // Two-stage return path: FIFO data arrives one cycle after r_en, then is registered out.
    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            pend_q       <= 1'b0;
            pend_owner_q <= '0;
            data_q       <= '0;
            valid_q      <= '0;
        end else begin
            pend_q       <= r_en;
            pend_owner_q <= owner_q;
            valid_q      <= '0;
            if (pend_q) begin
                valid_q[pend_owner_q] <= 1'b1;
                data_q                <= bus.mem_data_out;
            end
        end
    end

    assign bus.r_en     = r_en;
    assign bus.gnt      = gnt_q;
    assign bus.data_out = data_q;
    assign bus.rd_valid = valid_q;
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench for fifo_rd_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level model of grants, bursts and deliveries.
`timescale 1ns/100ps
module tb_fifo_rd_arbiter;
    localparam int DW  = 32;
    localparam int NR  = 4;
    localparam int BM  = 4;
    localparam int TO  = 16;
    localparam int TAB = 4096;

    logic clk = 1'b0;
    logic rrst_n;
    always #5 clk = ~clk;

    fifo_rd_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    fifo_rd_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_MAX(BM), .TIMEOUT_CYC(TO)
    ) dut (
        .r_clk (clk),
        .rrst_n(rrst_n),
        .bus   (bus)
    );

    typedef struct {
        int            cyc;
        int            who;
        logic [DW-1:0] data;
    } deliv_t;

    deliv_t        dq[$];
    logic [DW-1:0] mem_tab[TAB];
    int            cyc;
    int            n_checks, n_pass, n_fail;
    int            m_owner, m_last, m_words, m_stall;
    logic [DW-1:0] m_dout;
    logic [NR-1:0] obs_gnt;
    logic          obs_ren;
    int            rv_cnt[NR];
    int            ren_total;
    logic [NR-1:0] gnt_seq[$];
    bit            tog_en;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = NR - 1;
        m_words = 0;
        m_stall = 0;
        m_dout  = '0;
        dq.delete();
    endtask

    // One clock cycle: compare at negedge, advance the model, then move to posedge+1.
    task automatic cycle();
        logic [NR-1:0] e_gnt, e_rv, req;
        logic [DW-1:0] e_dout;
        logic          e_ren, emp;
        bit            rel, found;
        @(negedge clk);
        req    = bus.rd_req;
        emp    = bus.f_empty;
        e_gnt  = (m_owner < 0) ? '0 : (NR'(1) << m_owner);
        e_ren  = (m_owner >= 0) && !emp && req[m_owner];
        e_rv   = '0;
        e_dout = m_dout;
        if (dq.size() > 0 && dq[0].cyc == cyc) begin
            e_rv[dq[0].who] = 1'b1;
            e_dout          = dq[0].data;
            m_dout          = dq[0].data;
            void'(dq.pop_front());
        end
        check("gnt", bus.gnt, e_gnt);
        check("r_en", bus.r_en, e_ren);
        check("rd_valid", bus.rd_valid, e_rv);
        check("data_out", bus.data_out, e_dout);
        if (bus.gnt != 0 && obs_gnt == 0) gnt_seq.push_back(bus.gnt);
        obs_gnt = bus.gnt;
        obs_ren = bus.r_en;
        if (bus.r_en) ren_total++;
        for (int i = 0; i < NR; i++) if (bus.rd_valid[i]) rv_cnt[i]++;

        if (m_owner < 0) begin
            found = 0;
            for (int k = 1; k <= NR; k++) begin
                if (!found && req[(m_last + k) % NR]) begin
                    m_owner = (m_last + k) % NR;
                    found   = 1;
                end
            end
            m_words = 0;
            m_stall = 0;
        end else begin
            if (e_ren) begin
                m_words++;
                m_stall = 0;
                dq.push_back('{cyc + 2, m_owner, mem_tab[(cyc + 1) % TAB]});
            end else if (emp) begin
                m_stall++;
            end
            rel = !req[m_owner] || (e_ren && m_words == BM);
`ifdef RD_ARB_TIMEOUT_EN
            if (m_stall == TO) rel = 1;
`endif
            if (rel) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        bus.mem_data_out = mem_tab[cyc % TAB];
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rrst_n = 1'b0;
        model_reset();
        obs_gnt = '0;
        @(posedge clk);
        #1 rrst_n = 1'b1;
        cyc++;
        bus.mem_data_out = mem_tab[cyc % TAB];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int viol, ren_c, rv2, rvother, k;
        n_checks = 0; n_pass = 0; n_fail = 0; cyc = 0; ren_total = 0; tog_en = 0;
        obs_gnt = '0;
        for (int i = 0; i < TAB; i++) mem_tab[i] = $urandom;
        for (int i = 0; i < NR; i++) rv_cnt[i] = 0;
        bus.rd_req = '0; bus.f_empty = 1'b1; bus.mem_data_out = mem_tab[0];
        rrst_n = 1'b1;
        #1 rrst_n = 1'b0;
        model_reset();
        #1;
        check("rst_gnt", bus.gnt, 0);
        check("rst_r_en", bus.r_en, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_data_out", bus.data_out, 0);
        @(posedge clk);
        #1 rrst_n = 1'b1;

        // Lone continuous requester: 4 reads, 1 idle, repeating.
        bus.rd_req = 4'b0001; bus.f_empty = 1'b0;
        ren_total = 0;
        repeat (16) cycle();
        check("a_burst_rate", ren_total, 12);
        bus.rd_req = '0;
        repeat (4) cycle();

        // All request: strict rotation starting at consumer 0.
        apply_reset();
        gnt_seq.delete();
        for (int i = 0; i < NR; i++) rv_cnt[i] = 0;
        bus.rd_req = 4'b1111; bus.f_empty = 1'b0;
        repeat (25) cycle();
        check("b_seq_len", gnt_seq.size() >= 5, 1);
        if (gnt_seq.size() >= 5) begin
            check("b_grant0", gnt_seq[0], 4'b0001);
            check("b_grant1", gnt_seq[1], 4'b0010);
            check("b_grant2", gnt_seq[2], 4'b0100);
            check("b_grant3", gnt_seq[3], 4'b1000);
            check("b_grant4", gnt_seq[4], 4'b0001);
        end
        check("b_rv_cnt3", rv_cnt[3], BM);
        bus.rd_req = '0;
        repeat (4) cycle();

        // f_empty toggling asynchronously every 8 ns; sample just before each rising edge.
        apply_reset();
        bus.rd_req = 4'b0100; bus.f_empty = 1'b0;
        tog_en = 1;
        fork
            begin
                while (tog_en) #8 bus.f_empty = ~bus.f_empty;
            end
        join_none
        viol = 0; ren_c = 0; rv2 = 0; rvother = 0;
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            #4.5;
            if (bus.r_en && bus.f_empty) viol++;
            if (bus.r_en) ren_c++;
            if (bus.rd_valid[2]) rv2++;
            if ((bus.rd_valid & 4'b1011) != 0) rvother++;
            if (i == 39) bus.rd_req = '0;
        end
        tog_en = 0;
        #10;
        bus.f_empty = 1'b0;
        check("c_ren_while_empty", viol, 0);
        check("c_reads_seen", ren_c > 0, 1);
        check("c_valid_eq_reads", rv2, ren_c);
        check("c_other_valid", rvother, 0);

        // Consumer 1 drops after two words while consumer 3 waits.
        apply_reset();
        for (int i = 0; i < NR; i++) rv_cnt[i] = 0;
        bus.rd_req = 4'b1010; bus.f_empty = 1'b0;
        k = 0;
        while (!(m_owner == 1 && m_words == 2) && k < 10) begin
            cycle();
            k++;
        end
        check("d_two_words_bound", k < 10, 1);
        bus.rd_req = 4'b1000;
        cycle();
        check("d_hold_gnt", obs_gnt, 4'b0010);
        check("d_no_read_on_drop", obs_ren, 0);
        cycle();
        check("d_release", obs_gnt, 4'b0000);
        cycle();
        check("d_next_gnt", obs_gnt, 4'b1000);
        repeat (3) cycle();
        check("d_rv1_cnt", rv_cnt[1], 2);
        bus.rd_req = '0;
        repeat (4) cycle();

        // Asynchronous reset in the middle of a burst with words in flight.
        apply_reset();
        bus.rd_req = 4'b0001; bus.f_empty = 1'b0;
        repeat (5) cycle();
        @(negedge clk);
        #2 rrst_n = 1'b0;
        model_reset();
        obs_gnt = '0;
        #1;
        check("e_gnt_zero", bus.gnt, 0);
        check("e_r_en_zero", bus.r_en, 0);
        check("e_rd_valid_zero", bus.rd_valid, 0);
        check("e_data_out_zero", bus.data_out, 0);
        bus.rd_req = 4'b1010;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rrst_n = 1'b1;
        cyc++;
        bus.mem_data_out = mem_tab[cyc % TAB];
        cycle();
        cycle();
        check("e_first_gnt", obs_gnt, 4'b0010);
        repeat (6) cycle();
        bus.rd_req = '0;
        repeat (4) cycle();

        // Randomized traffic against the model.
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) bus.rd_req = NR'($urandom);
            bus.f_empty = ($urandom_range(0, 3) == 0);
            cycle();
        end
        bus.rd_req = '0;
        repeat (4) cycle();

        // Empty FIFO with two requesters: grant moves only when the timeout is built in.
        apply_reset();
        bus.rd_req = 4'b0011; bus.f_empty = 1'b1;
        repeat (26) cycle();
`ifdef RD_ARB_TIMEOUT_EN
        check("g_timeout_gnt", obs_gnt, 4'b0010);
`else
        check("g_hold_gnt", obs_gnt, 4'b0001);
`endif
        bus.rd_req = '0;
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
